ifetch_pf: RTL

- Parametrised, prefetching successor to the single-entry fetch stage.
- Keeps a fetch PC and issues sequential requests to instruction memory over a req/gnt + rvalid interface, allowing arbitrary in-order latency of at least 1 cycle.
- Buffers returned instructions, each tagged with its PC, in a DEPTH-entry queue and presents them to decode with a valid/ready handshake.
- A redirect (branch, call or return, already resolved by the ctrl unit) flushes the queue and discards in-flight responses.

---
 rtl/ifetch_pf_pkg.sv | 21 ++
 rtl/ifetch_pf_fifo.sv | 61 ++++++
 rtl/ifetch_pf.sv | 106 ++++++++++
 3 files changed

// File: rtl/ifetch_pf_pkg.sv
// +--------------------------------------------------------------------+
// | ifetch_pf_pkg                                                        |
// | Default widths and reset PC for the prefetching fetch stage.         |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
`default_nettype none

package ifetch_pf_pkg;

   localparam int DEF_ADDR_W   = 12;
   localparam int DEF_INST_W   = 8;
   localparam int DEF_RESET_PC = 0;

   // Width of one queue entry: {pc, inst}
   function automatic int entry_w(input int addr_w, input int inst_w);
      return addr_w + inst_w;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ifetch_pf_fifo.sv
// +--------------------------------------------------------------------+
// | ifetch_pf_fifo                                                       |
// | Synchronous circular-buffer FIFO with flush, full/empty and count.   |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
`default_nettype none

module ifetch_pf_fifo #(
   parameter int WIDTH = 20,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage needs no reset; validity is tracked by count alone
   always_ff @(posedge clk) begin
      if (do_push && !flush && !reset)
         mem[wr_ptr] <= din;
   end

endmodule

`default_nettype wire

// File: rtl/ifetch_pf.sv
// +--------------------------------------------------------------------+
// | ifetch_pf                                                            |
// | Prefetching instruction fetch with credit-limited requests,          |
// | PC-tagged queue and redirect flush of in-flight responses.           |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
`default_nettype none

module ifetch_pf
   import ifetch_pf_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int INST_W   = DEF_INST_W,
   parameter int DEPTH    = 4,
   parameter int RESET_PC = DEF_RESET_PC
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_addr,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_gnt,
   input  logic              imem_rvalid,
   input  logic [INST_W-1:0] imem_rdata,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [INST_W-1:0] inst_o,
   output logic [ADDR_W-1:0] inst_pc,
   output logic [ADDR_W-1:0] next_pc
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int EW = entry_w(ADDR_W, INST_W);

   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] resp_pc;
   logic [CW-1:0]     inflight;
   logic [CW-1:0]     discard;
   logic [CW-1:0]     count;
   logic [CW:0]       credit_used;
   logic [CW-1:0]     rv_dec;
   logic              accept;
   logic              dropping;
   logic              push;
   logic              pop;
   logic              full;
   logic              empty;
   logic [EW-1:0]     head;

   // Responses still owed to the queue are in-flight minus those to be dropped
   assign credit_used = {1'b0, count} + {1'b0, inflight - discard};
   assign imem_req    = !reset && !redirect && (credit_used < (CW+1)'(DEPTH));
   assign imem_addr   = fetch_pc;
   assign accept      = imem_req && imem_gnt;
   assign dropping    = (discard != '0);
   assign rv_dec      = CW'(imem_rvalid);
   assign push        = imem_rvalid && !redirect && !dropping && !full;
   assign pop         = inst_valid && inst_ready && !redirect;

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc <= ADDR_W'(RESET_PC);
         resp_pc  <= ADDR_W'(RESET_PC);
         inflight <= '0;
         discard  <= '0;
      end else if (redirect) begin
         fetch_pc <= redirect_addr;
         resp_pc  <= redirect_addr;
         inflight <= inflight - rv_dec;
         discard  <= inflight - rv_dec;
      end else begin
         if (accept)
            fetch_pc <= fetch_pc + ADDR_W'(1);
         inflight <= inflight + CW'(accept) - rv_dec;
         if (imem_rvalid && dropping)
            discard <= discard - CW'(1);
         if (push)
            resp_pc <= resp_pc + ADDR_W'(1);
      end
   end

   ifetch_pf_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (redirect),
      .push  (push),
      .pop   (pop),
      .din   ({resp_pc, imem_rdata}),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   assign inst_valid = !empty;
   assign inst_pc    = head[EW-1:INST_W];
   assign inst_o     = head[INST_W-1:0];
   assign next_pc    = inst_pc + ADDR_W'(1);

endmodule

`default_nettype wire
